// File: rtl/nn_phase_seq.sv
`default_nettype none
// ============================================================================
// Module   : nn_phase_seq
// Brief    : N-layer forward/backward phase sequencer with TR/VL/END commands.
//            Optional handoff overlap enabled by NN_PHASE_SEQ_OVERLAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module nn_phase_seq #(
    parameter int N_LAYERS = 2,
    parameter int FWD_LEN  = 5,
    parameter int BWD_LEN  = 16,
    parameter int CNT_W    = $clog2(((FWD_LEN > BWD_LEN) ? FWD_LEN : BWD_LEN) + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                TR,
    input  logic                VL,
    input  logic                END,
    output logic [N_LAYERS-1:0] FP,
    output logic [N_LAYERS-1:0] BP,
    output logic                S_Train,
    output logic                S_Error,
    output logic                busy
);

    localparam int LYR_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
    localparam logic [LYR_W-1:0] c_LAST_LYR = LYR_W'(N_LAYERS - 1);
    localparam logic [CNT_W-1:0] c_FWD_END  = CNT_W'(FWD_LEN - 1);
    localparam logic [CNT_W-1:0] c_BWD_END  = CNT_W'(BWD_LEN - 1);
`ifdef NN_PHASE_SEQ_OVERLAP_EN
    localparam bit c_OVERLAP = 1'b1;
`else
    localparam bit c_OVERLAP = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_BWD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [LYR_W-1:0]    r_lyr, w_lyr_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                r_trn, w_trn_nxt;
    logic                w_seg_change;
    logic [N_LAYERS-1:0] w_cur_fp, w_cur_bp;
    logic [N_LAYERS-1:0] w_fp_nxt, w_bp_nxt;
    logic                w_train_nxt, w_error_nxt, w_busy_nxt;

    always_comb begin
        w_state_nxt  = r_state;
        w_lyr_nxt    = r_lyr;
        w_cnt_nxt    = r_cnt;
        w_trn_nxt    = r_trn;
        w_seg_change = 1'b0;
        if (TR || VL) begin
            w_state_nxt = S_FWD;
            w_lyr_nxt   = '0;
            w_cnt_nxt   = '0;
            w_trn_nxt   = TR;
        end else if (END) begin
            w_state_nxt = S_IDLE;
            w_lyr_nxt   = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_FWD: begin
                    if (r_cnt == c_FWD_END) begin
                        w_cnt_nxt = '0;
                        if (r_lyr != c_LAST_LYR) begin
                            w_lyr_nxt    = r_lyr + 1'b1;
                            w_seg_change = 1'b1;
                        end else if (r_trn) begin
                            w_state_nxt  = S_BWD;
                            w_seg_change = 1'b1;
                        end else begin
                            w_state_nxt = S_DONE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_BWD: begin
                    if (r_cnt == c_BWD_END) begin
                        w_cnt_nxt = '0;
                        if (r_lyr != '0) begin
                            w_lyr_nxt    = r_lyr - 1'b1;
                            w_seg_change = 1'b1;
                        end else begin
                            w_state_nxt = S_DONE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they leave the flops aligned with it.
    always_comb begin
        w_cur_fp    = (r_state == S_FWD) ? (N_LAYERS'(1) << r_lyr) : '0;
        w_cur_bp    = (r_state == S_BWD) ? (N_LAYERS'(1) << r_lyr) : '0;
        w_fp_nxt    = '0;
        w_bp_nxt    = '0;
        w_train_nxt = 1'b0;
        w_error_nxt = 1'b0;
        case (w_state_nxt)
            S_FWD:   w_fp_nxt = N_LAYERS'(1) << w_lyr_nxt;
            S_BWD:   w_bp_nxt = N_LAYERS'(1) << w_lyr_nxt;
            S_DONE: begin
                w_train_nxt = w_trn_nxt;
                w_error_nxt = !w_trn_nxt;
            end
            default: ;
        endcase
        if (c_OVERLAP && w_seg_change) begin
            w_fp_nxt = w_fp_nxt | w_cur_fp;
            w_bp_nxt = w_bp_nxt | w_cur_bp;
        end
        w_busy_nxt = (w_state_nxt == S_FWD) || (w_state_nxt == S_BWD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_lyr   <= '0;
            r_cnt   <= '0;
            r_trn   <= 1'b0;
            FP      <= '0;
            BP      <= '0;
            S_Train <= 1'b0;
            S_Error <= 1'b0;
            busy    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lyr   <= w_lyr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_trn   <= w_trn_nxt;
            FP      <= w_fp_nxt;
            BP      <= w_bp_nxt;
            S_Train <= w_train_nxt;
            S_Error <= w_error_nxt;
            busy    <= w_busy_nxt;
        end
    end

endmodule
`default_nettype wire
